// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared state, class, opcode and control encodings for the multi-cycle MIPS controller
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_BR  = 3'd5,
      S_JMP = 3'd6,
      S_ERR = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_RTYPE, C_ORI, C_SLTI, C_LUI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_ILL
   } cls_t;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;

   // Same codes as the single-cycle decoder's ctrl_encode_def.v
   localparam logic [1:0] EXT_ZERO    = 2'b00;
   localparam logic [1:0] EXT_SIGNED  = 2'b01;
   localparam logic [1:0] EXT_HIGHPOS = 2'b10;

   localparam logic [4:0] ALUOP_NOP = 5'b00000;
   localparam logic [4:0] ALUOP_LUI = 5'b00001;
   localparam logic [4:0] ALUOP_ADD = 5'b00011;
   localparam logic [4:0] ALUOP_SUB = 5'b00100;
   localparam logic [4:0] ALUOP_SLT = 5'b01010;
   localparam logic [4:0] ALUOP_OR  = 5'b01101;
   localparam logic [4:0] ALUOP_AND = 5'b01110;
   localparam logic [4:0] ALUOP_SLL = 5'b01111;
   localparam logic [4:0] ALUOP_SRL = 5'b10000;
   localparam logic [4:0] ALUOP_SRA = 5'b10001;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_SLL = 6'b000000;
   localparam logic [5:0] F_SRL = 6'b000010;
   localparam logic [5:0] F_SRA = 6'b000011;
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   typedef struct packed {
      cls_t       cls;
      logic [4:0] aluctrl;
      logic [1:0] extop;
      logic       regdst;
      logic       shift;
   } dec_t;

   typedef struct packed {
      logic       mem_r;
      logic       mem_w;
      logic       i_or_d;
      logic       ir_wr;
      logic       pc_wr;
      logic [1:0] npc_sel;
      logic       regdst;
      logic       regw;
      logic       mem2r;
      logic       alusrc;
      logic       shift;
      logic [1:0] extop;
      logic [4:0] aluctrl;
      logic       err;
   } out_t;

   function automatic logic is_mem(input cls_t c);
      return c == C_LW || c == C_SW;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller-to-datapath/memory signal bundle
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
   logic [5:0]       OpCode;
   logic [5:0]       funct;
   logic             zero;
   logic             mem_ready;
   logic             mem_r;
   logic             mem_w;
   logic             i_or_d;
   logic             ir_wr;
   logic             pc_wr;
   logic [1:0]       npc_sel;
   logic             RegDst;
   logic             RegW;
   logic             Mem2R;
   logic             Alusrc;
   logic             shift;
   logic [1:0]       ExtOp;
   logic [4:0]       Aluctrl;
   logic             err;
   logic [CNT_W-1:0] retired;

   modport master (
      input  OpCode, funct, zero, mem_ready,
      output mem_r, mem_w, i_or_d, ir_wr, pc_wr, npc_sel, RegDst, RegW, Mem2R,
             Alusrc, shift, ExtOp, Aluctrl, err, retired
   );

   modport slave (
      output OpCode, funct, zero, mem_ready,
      input  mem_r, mem_w, i_or_d, ir_wr, pc_wr, npc_sel, RegDst, RegW, Mem2R,
             Alusrc, shift, ExtOp, Aluctrl, err, retired
   );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_decode: maps OpCode/funct to instruction class and execute-stage controls
module multicycle_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] OpCode,
   input  logic [5:0] funct,
   output dec_t       dec,
   output logic       illegal
);
   always_comb begin
      dec.cls = C_ILL;
      dec.aluctrl = ALUOP_NOP;
      dec.extop = EXT_ZERO;
      dec.regdst = 1'b0;
      dec.shift = 1'b0;
      case (OpCode)
         OP_RTYPE: begin
            dec.cls = C_RTYPE;
            dec.regdst = 1'b1;
            case (funct)
               F_SLL: begin dec.aluctrl = ALUOP_SLL; dec.shift = 1'b1; end
               F_SRL: begin dec.aluctrl = ALUOP_SRL; dec.shift = 1'b1; end
               F_SRA: begin dec.aluctrl = ALUOP_SRA; dec.shift = 1'b1; end
               F_ADD: dec.aluctrl = ALUOP_ADD;
               F_AND: dec.aluctrl = ALUOP_AND;
               F_OR:  dec.aluctrl = ALUOP_OR;
               F_SLT: dec.aluctrl = ALUOP_SLT;
               default: begin dec.cls = C_ILL; dec.regdst = 1'b0; end
            endcase
         end
         OP_ORI:  begin dec.cls = C_ORI;  dec.aluctrl = ALUOP_OR;  dec.extop = EXT_ZERO;    end
         OP_SLTI: begin dec.cls = C_SLTI; dec.aluctrl = ALUOP_SLT; dec.extop = EXT_SIGNED;  end
         OP_LUI:  begin dec.cls = C_LUI;  dec.aluctrl = ALUOP_LUI; dec.extop = EXT_HIGHPOS; end
         OP_LW:   begin dec.cls = C_LW;   dec.aluctrl = ALUOP_ADD; dec.extop = EXT_SIGNED;  end
         OP_SW:   begin dec.cls = C_SW;   dec.aluctrl = ALUOP_ADD; dec.extop = EXT_SIGNED;  end
         OP_BEQ:  begin dec.cls = C_BEQ;  dec.aluctrl = ALUOP_SUB; end
         OP_BNE:  begin dec.cls = C_BNE;  dec.aluctrl = ALUOP_SUB; end
         OP_J:    dec.cls = C_J;
         default: dec.cls = C_ILL;
      endcase
   end

   assign illegal = dec.cls == C_ILL;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS main controller FSM with memory handshake and retire counter
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input logic                clk,
   input logic                rst,
   multicycle_ctrl_if.master  bus
);
   state_t           state, nxt;
   dec_t             dec, ir_dec;
   logic             illegal, retire, rdy;
   logic [CNT_W-1:0] cnt;
   out_t             o;

   multicycle_decode u_dec (
      .OpCode  (bus.OpCode),
      .funct   (bus.funct),
      .dec     (dec),
      .illegal (illegal)
   );

   assign rdy = bus.mem_ready;

   // Decoded class is captured in ID so later IR changes cannot disturb the instruction
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IF;
         ir_dec <= '0;
         cnt <= '0;
      end else begin
         state <= nxt;
         if (state == S_ID) ir_dec <= dec;
         if (retire) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      o = '0;
      nxt = state;
      retire = 1'b0;
      case (state)
         S_IF: begin
            o.mem_r = 1'b1;
            o.ir_wr = rdy;
            o.pc_wr = rdy;
            o.npc_sel = NPC_PLUS4;
            nxt = rdy ? S_ID : S_IF;
         end
         S_ID: begin
            o.aluctrl = ALUOP_ADD;
            o.alusrc = 1'b1;
            o.extop = EXT_SIGNED;
            nxt = dec.cls == C_J ? S_JMP :
                  (dec.cls == C_BEQ || dec.cls == C_BNE) ? S_BR :
                  illegal ? S_ERR : S_EXE;
         end
         S_EXE: begin
            o.aluctrl = ir_dec.aluctrl;
            o.alusrc = ir_dec.cls != C_RTYPE;
            o.shift = ir_dec.shift;
            o.extop = ir_dec.extop;
            nxt = is_mem(ir_dec.cls) ? S_MEM : S_WB;
         end
         S_MEM: begin
            o.i_or_d = 1'b1;
            o.mem_r = ir_dec.cls == C_LW;
            o.mem_w = ir_dec.cls == C_SW;
            nxt = !rdy ? S_MEM : ir_dec.cls == C_LW ? S_WB : S_IF;
            retire = rdy && ir_dec.cls == C_SW;
         end
         S_WB: begin
            o.regw = 1'b1;
            o.regdst = ir_dec.regdst;
            o.mem2r = ir_dec.cls == C_LW;
            nxt = S_IF;
            retire = 1'b1;
         end
         S_BR: begin
            o.aluctrl = ALUOP_SUB;
            o.pc_wr = (ir_dec.cls == C_BEQ && bus.zero) || (ir_dec.cls == C_BNE && !bus.zero);
            o.npc_sel = NPC_BRANCH;
            nxt = S_IF;
            retire = 1'b1;
         end
         S_JMP: begin
            o.pc_wr = 1'b1;
            o.npc_sel = NPC_JUMP;
            nxt = S_IF;
            retire = 1'b1;
         end
         S_ERR: o.err = 1'b1;
      endcase
   end

   // Every output reads zero while reset is asserted, even mid memory wait
   assign {bus.mem_r, bus.mem_w, bus.i_or_d, bus.ir_wr, bus.pc_wr, bus.npc_sel, bus.RegDst,
           bus.RegW, bus.Mem2R, bus.Alusrc, bus.shift, bus.ExtOp, bus.Aluctrl, bus.err} = rst ? '0 : o;
   assign bus.retired = rst ? '0 : cnt;
endmodule
